// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: blank pattern, arbiter state encoding, hex decoder.
// SEG_ARB_GAP_EN adds the one-cycle GAP state between owners.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1
`ifdef SEG_ARB_GAP_EN
    , ST_GAP = 2'd2
`endif
  } seg_state_t;

  // Segments a..g, MSB = a, active-high.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1110011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_share_arbiter_if.sv
// Requester/display bundle for seg_share_arbiter: sources drive req/nibble, arbiter drives grant/natural.
interface seg_share_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] nibble;
  logic [NREQ-1:0]   grant;
  logic [6:0]        natural;

  modport master (output req, output nibble, input grant, input natural);
  modport slave  (input req, input nibble, output grant, output natural);
endinterface

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first non-excluded request at or after ptr, wrapping.
module seg_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win,
  output logic            valid
);
  localparam int unsigned N = NREQ;

  logic [NREQ-1:0] cand;
  logic [IW-1:0]   idx;

  assign cand = req & ~excl;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!valid && cand[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin owner of a shared seven-segment digit with minimum dwell under contention.
// Define SEG_ARB_GAP_EN to insert a one-cycle blank GAP on every release.
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 4_000_000
) (
  input logic               clk,
  input logic               rst,
  seg_share_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  seg_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [6:0]      nat_q, nat_d;

  logic [NREQ-1:0] own_mask, pick_excl, pick_win;
  logic [IW-1:0]   pick_ptr, win_idx, inc_ptr;
  logic            pick_valid, others, dwell_done;

  seg_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++)
      if (pick_win[k]) win_idx = IW'(k);
  end

  always_comb begin
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
    others            = |(bus.req & ~own_mask);
    inc_ptr           = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    dwell_done        = (cnt_q == 32'(HOLD_CYCLES - 1));
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pick_ptr  = ptr_q;
    pick_excl = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          grant_d = pick_win;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        cnt_d     = dwell_done ? cnt_q : cnt_q + 32'd1;
        // Direct handover searches from the post-release pointer, skipping the old owner.
        pick_ptr  = inc_ptr;
        pick_excl = own_mask;
        if (!bus.req[owner_q] || (dwell_done && others)) begin
          ptr_d = inc_ptr;
`ifdef SEG_ARB_GAP_EN
          state_d = ST_GAP;
          grant_d = '0;
`else
          if (pick_valid) begin
            grant_d = pick_win;
            owner_d = win_idx;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
`endif
        end
      end
`ifdef SEG_ARB_GAP_EN
      ST_GAP: begin
        pick_excl = others ? own_mask : '0;
        if (pick_valid) begin
          state_d = ST_OWN;
          grant_d = pick_win;
          owner_d = win_idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    nat_d = (state_d == ST_OWN) ? seg7_decode(bus.nibble[{owner_d, 2'b00} +: 4]) : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      nat_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      nat_q   <= nat_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.natural = nat_q;
endmodule

// File: tb/tb_seg_share_arbiter.sv
// Scoreboard bench for seg_share_arbiter (NREQ=4, HOLD_CYCLES=4); honours SEG_ARB_GAP_EN.
module tb_seg_share_arbiter;
  localparam logic [6:0] BL = 7'b0000000;
  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1110011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] CSEG [4] = '{S2, S0, S2, S1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [10:0] exp_q [$];
  string       name_q [$];
  logic [10:0] e;
  string       nm;

  seg_share_arbiter_if #(.NREQ(4)) bus ();

  seg_share_arbiter #(.NREQ(4), .HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [15:0] nb,
                     input logic [3:0] eg, input logic [6:0] en, input string name);
    @(negedge clk);
    rst        = r;
    bus.req    = rq;
    bus.nibble = nb;
    exp_q.push_back({eg, en});
    name_q.push_back(name);
  endtask

  // Monitor: output after each rising edge is compared against the entry issued before it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.grant !== e[10:7] || bus.natural !== e[6:0]) begin
          errors++;
          $display("FAIL %s t=%0t grant=%b natural=%b required grant=%b natural=%b",
                   nm, $time, bus.grant, bus.natural, e[10:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    bus.req    = '0;
    bus.nibble = '0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 16'h1202, 4'b0000, BL, "reset");

    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++)
        cyc(1'b0, 4'b1111, 16'h1202, 4'b0001 << (r % 4), CSEG[r % 4], "contention");
`ifdef SEG_ARB_GAP_EN
      if (r < 4) cyc(1'b0, 4'b1111, 16'h1202, 4'b0000, BL, "gap");
`endif
    end
    cyc(1'b1, 4'b0000, 16'h1202, 4'b0000, BL, "reset_clear");

    for (int i = 0; i < 21; i++) cyc(1'b0, 4'b0100, 16'h0900, 4'b0100, S9, "single_hold");
    cyc(1'b0, 4'b0100, 16'h0A00, 4'b0100, SA, "nibble_track");
    cyc(1'b0, 4'b0000, 16'h0A00, 4'b0000, BL, "single_drop");
    cyc(1'b0, 4'b0000, 16'h0A00, 4'b0000, BL, "idle");

    cyc(1'b0, 4'b0010, 16'h0057, 4'b0010, S5, "owner1");
    cyc(1'b0, 4'b0011, 16'h0057, 4'b0010, S5, "owner1_dwell");
`ifdef SEG_ARB_GAP_EN
    cyc(1'b0, 4'b0001, 16'h0057, 4'b0000, BL, "early_drop_gap");
`endif
    cyc(1'b0, 4'b0001, 16'h0057, 4'b0001, S7, "early_drop");
    cyc(1'b0, 4'b0001, 16'h0057, 4'b0001, S7, "owner0");
    cyc(1'b1, 4'b0001, 16'h0057, 4'b0000, BL, "mid_reset");
    cyc(1'b0, 4'b1011, 16'h0057, 4'b0001, S7, "restart_ptr0");
    cyc(1'b0, 4'b0000, 16'h0057, 4'b0000, BL, "release");
    cyc(1'b0, 4'b0000, 16'h0057, 4'b0000, BL, "idle_end");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_share_arbiter.md
# seg_share_arbiter

Round-robin arbiter that shares a single seven-segment digit among up to eight requesters (date cycler, counters, status sources). Each requester raises `req` with a 4-bit hex nibble. The arbiter grants one owner at a time, holds it for a guaranteed minimum dwell, and drives the decoded segment pattern of the current owner. It sits between the display sources and the board's `natural` segment pins.

## Interface
- `NREQ`, 4 — number of requesters, legal range 2..8.
- `HOLD_CYCLES`, 4_000_000 — minimum grant dwell in clk cycles, ≥1; counter is 32-bit.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `req` in NREQ — request per requester, level; held high while it wants the display.
- `nibble` in 4*NREQ — requester i's digit at bits [4i+3:4i].
- `grant` out NREQ — one-hot current owner, all-zero when none.
- `natural` out 7 — segments a..g, MSB=a, active-high; blank = 7'b0000000.

## Operation
- States: IDLE (no owner), OWN (owner holds display), GAP (only with macro).
- Round-robin pointer `ptr` = index after the last owner. Search order is ptr, ptr+1, … wrapping modulo NREQ. First `req` high wins.
- IDLE:
  - any `req` high → grant winner, `cnt`←0, go to OWN;
  - else stay, `grant`=0, `natural` blank.
- OWN: `cnt` increments each cycle, saturating at HOLD_CYCLES-1.
  - Owner `req` low → release immediately, regardless of `cnt`.
  - Owner `req` high, `cnt`==HOLD_CYCLES-1, and another `req` high → release (preemption allowed only after dwell).
  - Owner `req` high, no other request → keep ownership indefinitely.
- On release (macro off):
  - other requester pending → hand over on the same edge to the next round-robin winner, excluding the releasing owner; `cnt`←0.
  - none pending → IDLE.
- On release, `ptr` ← owner+1 mod NREQ.
- Decode per hex digit, 0..F:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000;
  - 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

## Timing
- Reset: `grant`=0, `natural`=7'b0000000, state IDLE, `ptr`=0, `cnt`=0. Reset mid-grant drops ownership on that edge; no pending handover survives.
- `req` sampled at posedge. `grant` is registered and changes on the edge after the qualifying `req` sample.
- `natural` is registered from the next-state owner's nibble, so it changes on the same edge as `grant`. While owning it tracks nibble changes with 1-cycle latency.
- Minimum contiguous ownership under contention is HOLD_CYCLES cycles.
- Simultaneous owner-drop and new request resolve in a single cycle (macro off). No cycle with zero grant while requests are pending.
- `ptr` wraps from NREQ-1 to 0.

## Configuration
- `SEG_ARB_GAP_EN` defined: every release enters GAP for exactly one cycle.
  - During GAP, `grant`=0 and `natural` blank.
  - On leaving GAP, arbitrate as in IDLE using the updated `ptr`; a requester that has just released but still requests is eligible only if no other requester is pending.
- `SEG_ARB_GAP_EN` undefined: GAP state does not exist; handover is direct as in Operation.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK` constant;
  - state enum;
  - `seg7_decode` function, shared with existing display blocks.
- One sub-module, `seg_rr_pick`: combinational round-robin picker. Inputs: req vector, ptr, exclude mask. Outputs: one-hot winner and valid.

## Test plan
Bench parameters: NREQ=4, HOLD_CYCLES=4.
- Reset: `rst`=1 with req=4'b1111 → `grant`=0 and `natural`=0000000 throughout; first edge after release of `rst` → `grant`=0001.
- Single owner: req=0100, nibble2=9 → `grant`=0100 and `natural`=1110011 next edge. Held 20 cycles with no other request → no change.
- Contention: req=1111, nibbles 2,0,2,1 → grant sequence 0001,0010,0100,1000,0001, each exactly 4 cycles; natural follows 1101101,1111110,1101101,0110000.
- Early drop: owner 1 drops req after 2 cycles while req0 is pending → `grant`=0001 on the next edge; `ptr`=2.
- Mid-grant reset: assert `rst` in cycle 2 of an ownership → `grant`=0 and blank next edge; arbitration restarts from requester 0.
- Macro on: repeat the contention test → a one-cycle `grant`=0, blank gap between owners; each cycle is 5 edges.
